// File: rtl/sequence_generator.sv
// sequence_generator: serial MSB-first pattern transmitter with busy/done handshake.
// Optional seamless repeat mode is enabled by defining SEQGEN_REPEAT_EN.
module sequence_generator #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
`ifdef SEQGEN_REPEAT_EN
    // repeat request; named repeat_req because "repeat" is a reserved word
    input  logic             repeat_req,
`endif
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_c;
    logic             accept;
`ifdef SEQGEN_REPEAT_EN
    logic [LEN_W-1:0] len_q, len_d;
`endif

    function automatic logic bit_at(input logic [WIDTH-1:0] v, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    always_comb begin
        len_c   = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
        // the DONE cycle is the mandatory gap, so a start at its closing edge begins the next transfer
        accept  = start && (state_q != SEND);
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SEQGEN_REPEAT_EN
        len_d   = len_q;
`endif
        if (accept) begin
            state_d = SEND;
            shift_d = pattern;
            cnt_d   = len_c - 1'b1;
            out_d   = bit_at(pattern, len_c - 1'b1);
            valid_d = 1'b1;
            busy_d  = 1'b1;
`ifdef SEQGEN_REPEAT_EN
            len_d   = len_c;
`endif
        end else if (state_q == SEND) begin
            busy_d = 1'b1;
            if (cnt_q != '0) begin
                cnt_d   = cnt_q - 1'b1;
                out_d   = bit_at(shift_q, cnt_q - 1'b1);
                valid_d = 1'b1;
            end
`ifdef SEQGEN_REPEAT_EN
            else if (repeat_req) begin
                cnt_d   = len_q - 1'b1;
                out_d   = bit_at(shift_q, len_q - 1'b1);
                valid_d = 1'b1;
            end
`endif
            else begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQGEN_REPEAT_EN
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQGEN_REPEAT_EN
            len_q   <= len_d;
`endif
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed and randomized checks of sequence_generator
// against a bit-list model built from pattern and clamped length.
module tb_sequence_generator;

    typedef logic bq_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'h0;
    logic       out, valid, busy, done;
`ifdef SEQGEN_REPEAT_EN
    logic       repeat_req = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sequence_generator #(.WIDTH(8), .LEN_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .pattern(pattern),
        .len(len),
`ifdef SEQGEN_REPEAT_EN
        .repeat_req(repeat_req),
`endif
        .out(out),
        .valid(valid),
        .busy(busy),
        .done(done)
    );

    // expected serial bits: pattern[L-1] down to pattern[0], L clamped to 8
    function automatic bq_t model(input logic [7:0] p, input logic [3:0] l);
        bq_t q;
        int  n;
        n = (l == 0 || l > 8) ? 8 : int'(l);
        for (int i = n - 1; i >= 0; i--) q.push_back(p[i]);
        return q;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed out/valid/busy/done=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        tick;
        chk(tag, {out, valid, busy, done}, 4'b0000);
    endtask

    // drives start for one edge, checks every bit and the done cycle; returns in the done cycle
    task automatic xfer(input logic [7:0] p, input logic [3:0] l, input bit poke, input string tag);
        bq_t q;
        q = model(p, l);
        pattern = p;
        len = l;
        start = 1'b1;
        tick;
        start = 1'b0;
        pattern = 8'($urandom);
        len = 4'($urandom);
        foreach (q[k]) begin
            if (k > 0) tick;
            chk($sformatf("%s bit%0d", tag, k), {out, valid, busy, done}, {q[k], 3'b110});
            if (poke && k == 1) begin
                start = 1'b1;
                pattern = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        tick;
        chk($sformatf("%s done", tag), {out, valid, busy, done}, 4'b0011);
    endtask

    initial begin
        #1;
        reset = 1'b0;
        start = 1'b1;
        pattern = 8'($urandom);
        len = 4'($urandom);
        #1;
        chk("reset async", {out, valid, busy, done}, 4'b0000);
        tick;
        chk("reset held edge1", {out, valid, busy, done}, 4'b0000);
        tick;
        chk("reset held edge2", {out, valid, busy, done}, 4'b0000);
        start = 1'b0;
        #3;
        reset = 1'b1;
        idle_chk("post reset idle1");
        idle_chk("post reset idle2");

        xfer(8'b0000_1011, 4'd4, 1'b0, "basic");
        idle_chk("basic idle");
        xfer(8'hA5, 4'd0, 1'b0, "clamp len0");
        idle_chk("clamp len0 idle");
        xfer(8'hA5, 4'd12, 1'b0, "clamp len12");
        idle_chk("clamp len12 idle");
        xfer(8'hC6, 4'd4, 1'b1, "ignore busy");
        xfer(8'h3C, 4'd4, 1'b0, "back to back");
        idle_chk("back to back idle");
        xfer(8'h01, 4'd1, 1'b0, "one bit");
        idle_chk("one bit idle");

        pattern = 8'hFF;
        len = 4'd8;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        #2;
        reset = 1'b0;
        #1;
        chk("abort async", {out, valid, busy, done}, 4'b0000);
        tick;
        chk("abort held", {out, valid, busy, done}, 4'b0000);
        #2;
        reset = 1'b1;
        idle_chk("abort released idle");
        xfer(8'b0000_0110, 4'd4, 1'b0, "after abort");
        idle_chk("after abort idle");

        for (int i = 0; i < 8; i++) begin
            xfer(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rand%0d idle", i));
        end
        idle_chk("rand final idle");

`ifdef SEQGEN_REPEAT_EN
        begin
            bq_t q;
            q = model(8'b0000_1011, 4'd4);
            repeat_req = 1'b1;
            pattern = 8'b0000_1011;
            len = 4'd4;
            start = 1'b1;
            tick;
            start = 1'b0;
            pattern = 8'($urandom);
            len = 4'($urandom);
            for (int k = 0; k < 12; k++) begin
                if (k > 0) tick;
                chk($sformatf("repeat bit%0d", k), {out, valid, busy, done}, {q[k % 4], 3'b110});
                if (k == 9) repeat_req = 1'b0;
            end
            tick;
            chk("repeat done", {out, valid, busy, done}, 4'b0011);
            idle_chk("repeat idle");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
